// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle iterative ARM LSL/LSR/ASR/ROR shifter for register-specified amounts.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             load request, accepted in IDLE or DONE
//   flush             abort to IDLE without a done pulse (beats start and the shift step)
//   shift_type        00 LSL, 01 LSR, 10 ASR, 11 ROR
//   val_rm, amount    operand and shift amount (Rs[7:0])
//   carry_in          current C flag
//   result, carry_out shifted value and shifter carry-out, held until the next load
//   done              one-cycle pulse when the result is ready
//   busy, stall       high while iterating; stall freezes the upstream pipeline
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  shift_type,
    input  logic [31:0] val_rm,
    input  logic [7:0]  amount,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        done,
    output logic        busy,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [5:0] STEP_W = 6'(STEP);
    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic [1:0]  type_q, type_d;
    logic [5:0]  rem_q, rem_d;
    logic [5:0]  k, rem_load;
    logic [31:0] shifted;
    logic        shift_c;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            type_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            type_q   <= type_d;
            rem_q    <= rem_d;
        end
    end
    // One iteration step; amounts beyond 32 are saturated to 33 so the final
    // single-bit step shifts out a zero (or the sign for ASR).
    always_comb begin
        k = rem_q < STEP_W ? rem_q : STEP_W;
        case (type_q)
            2'b00:   shifted = result_q << k;
            2'b01:   shifted = result_q >> k;
            2'b10:   shifted = $unsigned($signed(result_q) >>> k);
            default: shifted = (result_q >> k) | (result_q << (6'd32 - k));
        endcase
        shift_c = type_q == 2'b00 ? result_q[5'(6'd32 - k)] : result_q[5'(k - 6'd1)];
        rem_load = shift_type == 2'b11
                 ? (amount == 8'd0 ? 6'd0 : amount[4:0] == 5'd0 ? 6'd32 : {1'b0, amount[4:0]})
                 : (amount > 8'd33 ? 6'd33 : amount[5:0]);
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        type_d   = type_q;
        rem_d    = rem_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (start && state_q != SHIFT) begin
            result_d = val_rm;
            carry_d  = carry_in;
            type_d   = shift_type;
            rem_d    = rem_load;
            state_d  = rem_load == 6'd0 ? DONE : SHIFT;
        end else if (state_q == SHIFT) begin
            result_d = shifted;
            carry_d  = shift_c;
            rem_d    = rem_q - k;
            state_d  = rem_q == k ? DONE : SHIFT;
        end else begin
            state_d = IDLE;
        end
    end
    always_comb begin
        result    = result_q;
        carry_out = carry_q;
        done      = state_q == DONE;
        busy      = state_q == SHIFT;
        stall     = state_q == SHIFT;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle iterative shifter for register-specified shifts (amount taken from Rs[7:0]), which the single-cycle operand-2 path does not handle.
- Sits in the execute stage beside the operand-2 generator. It holds the pipeline via `stall` while it iterates.
- Returns the shifted value and the shifter carry-out to the ALU/status logic.
- Performs ARM LSL/LSR/ASR/ROR semantics, including amounts of 0 and 32 or more.

Parameters:
- STEP, 4, maximum bit positions shifted per iteration cycle (1..32).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request. Sampled only when state is IDLE or DONE.
- flush  input  1  abort any operation. Return to IDLE with no done.
- shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- val_rm  input  32  operand to shift.
- amount  input  8  shift amount (Rs[7:0]).
- carry_in  input  1  current C flag.
- result  output  32  shifted value. Valid while done=1, held until next accepted start.
- carry_out  output  1  shifter carry-out. Same validity as result.
- done  output  1  one-cycle pulse (state DONE).
- busy  output  1  high in state SHIFT.
- stall  output  1  equals busy. Freezes IF/ID/EX pipeline registers.

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, carry_out=0, done=0, busy=0, remaining=0, all internal registers cleared. Reset mid-SHIFT discards the operation with no done.
- States are IDLE, SHIFT and DONE. done = (state==DONE). busy = stall = (state==SHIFT).
- Load edge, when start=1 in IDLE or DONE:
  - result <= val_rm, carry_out <= carry_in, type latched.
  - remaining is computed as follows:
    - LSL/LSR/ASR: min(amount, 33).
    - ROR with amount=0: 0.
    - ROR with amount!=0 and amount[4:0]=0: 32.
    - ROR otherwise: amount[4:0].
  - Next state is DONE if remaining=0, else SHIFT.
- start=1 while in SHIFT is ignored; the requester must hold it.
- SHIFT edge:
  - k = min(remaining, STEP). Shift result by k per the latched type.
    - LSL zero-fills.
    - LSR zero-fills.
    - ASR replicates bit31.
    - ROR rotates.
  - carry_out <= the last bit shifted out:
    - LSL: bit 32-k of the pre-step value.
    - LSR/ASR/ROR: bit k-1 of the pre-step value.
  - remaining <= remaining-k. If that reaches 0, next state is DONE.
- Resulting architectural semantics, which iteration yields naturally:
  - amount=0: result = val_rm and carry_out = carry_in, for every type.
  - LSL: exactly 32 gives 0 with carry = bit0; above 32 gives 0 with carry 0.
  - LSR: exactly 32 gives 0 with carry = bit31; above 32 gives 0 with carry 0.
  - ASR ≥32: all bits equal to bit31, carry = bit31.
  - ROR by a nonzero multiple of 32: value unchanged, carry = bit31.
- DONE lasts one cycle. Next state is IDLE, or a new load if start=1 (back-to-back allowed).
- Latency: done is high after 1 + ceil(remaining/STEP) edges, counting from the load edge inclusive. Worst case with STEP=4 is 1+9 = 10 edges.
- flush=1 has priority over start and over the SHIFT step:
  - next state is IDLE and remaining is cleared;
  - result and carry_out keep their last values;
  - done is not pulsed.
- Arithmetic: remaining is 6 bits wide (max 33). All shifts operate on 32 bits and no sign/width extension leaks into result.

Test Plan:
1. LSL, val_rm=0x80000001, amount=1, carry_in=0 → result=0x00000002, carry_out=1, done on the 2nd edge.
2. LSR, val_rm=0x80000000, amount=32 → result=0, carry_out=1. busy is high for 8 cycles and done on edge 9. Repeat with amount=33 → result=0, carry_out=0.
3. ASR, val_rm=0x80000000, amount=200 → result=0xFFFFFFFF, carry_out=1, done after 10 edges, stall high for 9 cycles.
4. ROR, val_rm=0x000000F1, amount=4 → result=0x1000000F, carry_out=0. ROR, val_rm=0x80000001, amount=32 → result=0x80000001, carry_out=1.
5. amount=0 with each type, val_rm=0xDEADBEEF, carry_in=1 → result=0xDEADBEEF, carry_out=1, done on edge 1, busy never high. Also issue a back-to-back start during DONE and check it is accepted.
6. Start LSL amount=20, then flush=1 on the 2nd SHIFT cycle → IDLE next edge, no done pulse, stall drops. Repeat the same operation with rst pulsed mid-SHIFT → all outputs 0 immediately, asynchronously.
